// File: rtl/wb_xbar_pkg.sv
// Shared types and default SoC address map for the 1xN Wishbone crossbar.
package wb_xbar_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } xbar_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_DECODE  = 2'd1,
    CAUSE_TIMEOUT = 2'd2,
    CAUSE_SLAVE   = 2'd3
  } err_cause_e;

  localparam int DEF_N_SLAVES = 4;
  localparam int DEF_AW       = 32;

  // slave 0 = data memory, 1..3 = peripheral windows
  localparam logic [DEF_N_SLAVES*DEF_AW-1:0] DEF_SLAVE_BASE =
    {32'h2000_0200, 32'h2000_0100, 32'h2000_0000, 32'h0000_0000};
  localparam logic [DEF_N_SLAVES*DEF_AW-1:0] DEF_SLAVE_MASK =
    {32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_F000};

endpackage

// File: rtl/wb_xbar_1xn_if.sv
// Bus bundle for wb_xbar_1xn: upstream master lanes plus the packed per-slave lanes.
interface wb_xbar_1xn_if #(
  parameter int N_SLAVES = 4,
  parameter int AW       = 32,
  parameter int DW       = 32
);
  logic [AW-1:0]            m_adr_i;
  logic [DW-1:0]            m_dat_i;
  logic [DW/8-1:0]          m_sel_i;
  logic                     m_we_i;
  logic                     m_cyc_i;
  logic                     m_stb_i;
  logic [DW-1:0]            m_dat_o;
  logic                     m_ack_o;
  logic                     m_err_o;
  logic [N_SLAVES*AW-1:0]   s_adr_o;
  logic [N_SLAVES*DW-1:0]   s_dat_o;
  logic [N_SLAVES*DW/8-1:0] s_sel_o;
  logic [N_SLAVES-1:0]      s_we_o;
  logic [N_SLAVES-1:0]      s_cyc_o;
  logic [N_SLAVES-1:0]      s_stb_o;
  logic [N_SLAVES*DW-1:0]   s_dat_i;
  logic [N_SLAVES-1:0]      s_ack_i;
  logic [N_SLAVES-1:0]      s_err_i;

  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    output s_dat_i, s_ack_i, s_err_i
  );

  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    input  s_dat_i, s_ack_i, s_err_i
  );
endinterface

// File: rtl/wb_xbar_decode.sv
// Combinational address decoder: hit flag, one-hot select and index, lowest slave wins.
module wb_xbar_decode #(
  parameter int                     N_SLAVES   = 4,
  parameter int                     AW         = 32,
  parameter int                     IW         = 2,
  parameter logic [N_SLAVES*AW-1:0] SLAVE_BASE = '0,
  parameter logic [N_SLAVES*AW-1:0] SLAVE_MASK = '0
) (
  input  logic [AW-1:0]       adr_i,
  output logic                hit_o,
  output logic [N_SLAVES-1:0] onehot_o,
  output logic [IW-1:0]       idx_o
);

  logic found_s;

  // ascending scan; once found_s is set, higher slaves are masked off
  always_comb begin
    found_s  = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      onehot_o[i] = ((adr_i & SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW]) & ~found_s;
      idx_o       = onehot_o[i] ? IW'(i) : idx_o;
      found_s     = found_s | onehot_o[i];
    end
    hit_o = found_s;
  end

endmodule

// File: rtl/wb_xbar_1xn.sv
// 1-master to N-slave Wishbone classic crossbar with registered request/response,
// decode errors and a bus-timeout watchdog. Optional error log: WB_XBAR_ERRLOG_EN.
module wb_xbar_1xn
  import wb_xbar_pkg::*;
#(
  parameter int                     N_SLAVES   = 4,
  parameter int                     AW         = 32,
  parameter int                     DW         = 32,
  parameter int                     TIMEOUT    = 255,
  parameter logic [N_SLAVES*AW-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
  parameter logic [N_SLAVES*AW-1:0] SLAVE_MASK = DEF_SLAVE_MASK
) (
  input  logic          clk,
  input  logic          reset_n,
`ifdef WB_XBAR_ERRLOG_EN
  input  logic          err_clr_i,
  output logic          err_valid_o,
  output logic [AW-1:0] err_addr_o,
  output logic [1:0]    err_cause_o,
`endif
  wb_xbar_1xn_if.slave  bus
);

  localparam int SW = DW / 8;
  localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  xbar_state_e         state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [AW-1:0]       adr_q, adr_d;
  logic [DW-1:0]       dat_q, dat_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic [N_SLAVES-1:0] cyc_q, cyc_d;
  logic [N_SLAVES-1:0] we_q, we_d;
  logic [DW-1:0]       rdat_q, rdat_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic                dec_hit_s;
  logic [N_SLAVES-1:0] dec_onehot_s;
  logic [IW-1:0]       dec_idx_s;
  logic                sel_ack_s;
  logic                sel_err_s;
  logic [DW-1:0]       sel_dat_s;
  logic [CW-1:0]       cnt_inc_s;

  wb_xbar_decode #(
    .N_SLAVES   (N_SLAVES),
    .AW         (AW),
    .IW         (IW),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .adr_i    (bus.m_adr_i),
    .hit_o    (dec_hit_s),
    .onehot_o (dec_onehot_s),
    .idx_o    (dec_idx_s)
  );

  // only the latched slave may terminate the cycle
  assign sel_ack_s = bus.s_ack_i[idx_q];
  assign sel_err_s = bus.s_err_i[idx_q];
  assign sel_dat_s = bus.s_dat_i[idx_q*DW +: DW];
  assign cnt_inc_s = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);

  // next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.m_cyc_i && bus.m_stb_i) begin
          if (dec_hit_s) begin
            idx_d   = dec_idx_s;
            adr_d   = bus.m_adr_i;
            dat_d   = bus.m_dat_i;
            sel_d   = bus.m_sel_i;
            cyc_d   = dec_onehot_s;
            we_d    = bus.m_we_i ? dec_onehot_s : '0;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cyc_d = '0;
        we_d  = '0;
        if (!bus.m_cyc_i) begin
          state_d = IDLE;
        end else if (sel_err_s) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else if (sel_ack_s) begin
          rdat_d  = sel_dat_s;
          ack_d   = 1'b1;
          state_d = RESP;
        end else if (cnt_inc_s == CW'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          cyc_d   = cyc_q;
          we_d    = we_q;
          cnt_d   = cnt_inc_s;
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      cyc_q   <= '0;
      we_q    <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar g = 0; g < N_SLAVES; g++) begin : g_lane
    assign bus.s_adr_o[g*AW +: AW] = adr_q;
    assign bus.s_dat_o[g*DW +: DW] = dat_q;
    assign bus.s_sel_o[g*SW +: SW] = sel_q;
  end

  assign bus.s_cyc_o = cyc_q;
  assign bus.s_stb_o = cyc_q;
  assign bus.s_we_o  = we_q;
  assign bus.m_dat_o = rdat_q;
  assign bus.m_ack_o = ack_q;
  assign bus.m_err_o = err_q;

`ifdef WB_XBAR_ERRLOG_EN
  logic          log_valid_q;
  logic [AW-1:0] log_addr_q;
  err_cause_e    log_cause_q;
  err_cause_e    new_cause_s;
  logic [AW-1:0] new_addr_s;

  // classify the error being raised this cycle (err_d only fires on entry to ERR)
  always_comb begin
    if (state_q == IDLE) begin
      new_cause_s = CAUSE_DECODE;
      new_addr_s  = bus.m_adr_i;
    end else if (sel_err_s) begin
      new_cause_s = CAUSE_SLAVE;
      new_addr_s  = adr_q;
    end else begin
      new_cause_s = CAUSE_TIMEOUT;
      new_addr_s  = adr_q;
    end
  end

  // sticky first-error log, clear wins over a simultaneous capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      log_valid_q <= 1'b0;
      log_addr_q  <= '0;
      log_cause_q <= CAUSE_NONE;
    end else if (err_clr_i) begin
      log_valid_q <= 1'b0;
      log_addr_q  <= '0;
      log_cause_q <= CAUSE_NONE;
    end else if (err_d && !log_valid_q) begin
      log_valid_q <= 1'b1;
      log_addr_q  <= new_addr_s;
      log_cause_q <= new_cause_s;
    end
  end

  assign err_valid_o = log_valid_q;
  assign err_addr_o  = log_addr_q;
  assign err_cause_o = log_cause_q;
`endif

endmodule
